// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals
// shared by the arbiter (master) and its environment (slave).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          tx_done;
  logic                          send_data;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  logic                          timeout_err;

  modport master (
    input  req, req_data, tx_done,
    output ack, send_data, tx_data,
    output grant_id, busy, timeout_err
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, send_data, tx_data,
    input  grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter,
// with inter-frame gap and a done watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  localparam logic [7:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_WAIT, S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] w_byte;
  logic [IW-1:0]         r_grant_id;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         w_win;
  logic [WW-1:0]         r_wd;
  logic [WW-1:0]         w_wd_nxt;
  logic [WW-1:0]         w_wd_inc;
  logic [7:0]            r_gap;
  logic [7:0]            w_gap_nxt;
  logic                  r_timeout_err;
  logic                  w_found;
  logic                  w_grab;
  logic                  w_err_set;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int            v_idx;
    logic [IW-1:0] v_sel;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    v_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = (int'(r_last_grant) + k) % NUM_REQ;
      v_sel = IW'(v_idx);
      if (!w_found && bus.req[v_sel]) begin
        w_found = 1'b1;
        w_win   = v_sel;
      end
    end
  end

  // Pick the winner's byte out of the packed data bus.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i))
        w_byte = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_wd_inc = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;

  // Next-state and counter updates; done beats watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_gap_nxt   = r_gap;
    w_grab      = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grab      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_wd_nxt = w_wd_inc;
        if (bus.tx_done) begin
          w_gap_nxt   = '0;
          w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (w_wd_inc == WD_MAX) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
        else                   w_gap_nxt   = r_gap + 8'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched grant and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_last_grant  <= IW'(NUM_REQ - 1);
      r_wd          <= '0;
      r_gap         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wd    <= w_wd_nxt;
      r_gap   <= w_gap_nxt;
      if (w_grab) begin
        r_tx_data    <= w_byte;
        r_grant_id   <= w_win;
        r_last_grant <= w_win;
      end
      if (w_err_set) r_timeout_err <= 1'b1;
    end
  end

  assign bus.send_data   = (r_state == S_LOAD);
  assign bus.ack         = (r_state == S_LOAD) ?
                           (NUM_REQ'(1) << r_grant_id) : '0;
  assign bus.tx_data     = r_tx_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two configurations under random requesters,
// a random transmitter, and an event-timing reference model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input int c, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t",
               c, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N  = (g == 0) ? 4 : 3;
    localparam int G  = (g == 0) ? 0 : 3;
    localparam int T  = (g == 0) ? 24 : 10;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW),
      .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );

    int   e = 0;
    int   done_at = -1;
    int   m_last = N - 1;
    int   m_send = 0;
    int   m_resume = 0;
    int   m_gid = 0;
    int   m_data = 0;
    bit   m_wait = 1'b0;
    bit   m_err = 1'b0;
    bit   m_busy = 1'b0;
    int   q_edge[$];
    int   q_id[$];

    // Requesters and transmitter, driven on the falling edge.
    initial begin
      bus.req     = '1;
      bus.tx_done = 1'b0;
      for (int i = 0; i < N; i++)
        bus.req_data[i*DW +: DW] = DW'($urandom);
      forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if (rst) begin
            bus.req[IW'(i)] = 1'b1;
          end else if (bus.ack[IW'(i)]) begin
            bus.req[IW'(i)] = ($urandom_range(0, 1) == 0);
            bus.req_data[i*DW +: DW] = DW'($urandom);
          end else if (!bus.req[IW'(i)]) begin
            if ($urandom_range(0, 3) == 0) begin
              bus.req[IW'(i)] = 1'b1;
              bus.req_data[i*DW +: DW] = DW'($urandom);
            end
          end else if ($urandom_range(0, 39) == 0) begin
            bus.req[IW'(i)] = 1'b0;
          end
        end
        if (bus.send_data)
          done_at = e + (($urandom_range(0, 3) == 0) ? T :
                         int'($urandom_range(1, T + 2)));
        bus.tx_done = (e == done_at) ||
                      ($urandom_range(0, 29) == 0);
      end
    end

    // Reference model: arbitration edges and frame timing
    // derived from the sampled inputs only.
    initial begin
      forever begin
        bit found;
        int j;
        @(posedge clk);
        e++;
        if (rst) begin
          m_last = N - 1; m_wait = 1'b0; m_err = 1'b0;
          m_resume = 0; m_gid = 0; m_data = 0;
          q_edge.delete(); q_id.delete();
        end else if (m_wait) begin
          if (e >= m_send + 2) begin
            if (bus.tx_done) begin
              m_wait = 1'b0;
              m_resume = e + G + 1;
            end else if (e == m_send + T + 1) begin
              m_wait = 1'b0;
              m_err = 1'b1;
              m_resume = e + 1;
            end
          end
        end else if (e >= m_resume && bus.req != '0) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (!found && bus.req[IW'(j)]) begin
              found = 1'b1;
              m_last = j;
              m_gid = j;
              m_data = int'(bus.req_data[j*DW +: DW]);
            end
          end
          m_wait = 1'b1;
          m_send = e;
          q_edge.push_back(e);
          q_id.push_back(m_gid);
        end
        m_busy = m_wait || (e < m_resume - 1);
      end
    end

    // Monitor: per-cycle outputs and the send/ack scoreboard.
    initial begin
      forever begin
        logic [N-1:0] v_ack;
        @(negedge clk);
        chk(g, "busy", 32'(bus.busy), 32'(m_busy));
        chk(g, "timeout_err", 32'(bus.timeout_err), 32'(m_err));
        chk(g, "tx_data", 32'(bus.tx_data), 32'(m_data));
        chk(g, "grant_id", 32'(bus.grant_id), 32'(m_gid));
        if (q_edge.size() != 0 && q_edge[0] < e) begin
          chk(g, "send missing at edge", 32'(e), 32'(q_edge[0]));
          void'(q_edge.pop_front());
          void'(q_id.pop_front());
        end
        if (bus.send_data || bus.ack != '0) begin
          if (q_edge.size() == 0) begin
            chk(g, "unexpected send/ack",
                32'({bus.send_data, bus.ack}), 32'(0));
          end else begin
            v_ack = N'(1) << q_id[0];
            chk(g, "send edge", 32'(e), 32'(q_edge[0]));
            chk(g, "send_data", 32'(bus.send_data), 32'(1));
            chk(g, "ack", 32'(bus.ack), 32'(v_ack));
            void'(q_edge.pop_front());
            void'(q_id.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1 rst = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between NUM_REQ requesters with round-robin arbitration. It sits upstream of the transmitter control unit. It latches the winning requester's byte onto tx_data, issues a one-cycle send_data strobe, waits for the transmitter's done pulse, then enforces an optional inter-frame gap before re-arbitrating. A watchdog flags a transmitter that never reports done.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_WIDTH, 8: byte width
- GAP_CYCLES, 0: idle clocks inserted after each done, 0..255
- TIMEOUT_CYCLES, 65535: max clocks in WAIT before abort, ≥ 1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transfer request, level, held until ack
- req_data  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
- ack  out  NUM_REQ  one-hot one-cycle pulse: requester's byte accepted
- tx_done  in  1  transmitter frame-complete pulse (the transmitter's done)
- send_data  out  1  one-cycle start strobe to transmitter
- tx_data  out  DATA_WIDTH  byte to transmit, stable from LOAD until the next LOAD
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by rst

## Operation
- States: IDLE, LOAD, WAIT, GAP.
- IDLE: if any req bit is high, pick the winner by round-robin. The search starts at last_grant+1 mod NUM_REQ.
  - Register tx_data ← winner's req_data slice, grant_id ← winner, last_grant ← winner.
  - Go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD: send_data=1 and ack[grant_id]=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: increment the watchdog each cycle.
  - tx_done=1 → GAP if GAP_CYCLES>0, else IDLE.
  - Watchdog reaches TIMEOUT_CYCLES with no tx_done → set timeout_err, go to IDLE.
  - If tx_done and expiry occur in the same cycle, tx_done wins and timeout_err is not set.
- GAP: count GAP_CYCLES clocks (counter cleared on entry), then go to IDLE.
- tx_done outside WAIT is ignored.
- The grant is committed at arbitration. If the winner drops req before ack, the latched byte is still sent and ack still pulses.
- A requester still holding req after its ack is treated as a new request. Round-robin prevents it from starving others.
- rst mid-operation: return to IDLE and drive all outputs to reset values. An in-flight frame is abandoned; the transmitter is reset by its own reset.
- Width rules:
  - Watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - Gap counter is 8 bits.
  - The round-robin index wraps modulo NUM_REQ; NUM_REQ does not need to be a power of 2.

## Timing
- Reset values: state IDLE, send_data 0, ack 0, tx_data 0, grant_id 0, busy 0, timeout_err 0, last_grant NUM_REQ-1 (so requester 0 has first priority).
- Latency: req sampled high in IDLE at edge t → LOAD during cycle t+1 (send_data and ack high) → WAIT from t+2.
- Back-to-back with GAP_CYCLES=0: tx_done at cycle d → IDLE at d+1 → next send_data at d+2. This gives a minimum 2-cycle spacing between done and the next send.
- With GAP_CYCLES=G: next send_data no earlier than d+G+2.
- busy rises the cycle after arbitration (in LOAD) and falls on entry to IDLE.
- send_data and ack are always coincident and never high for two consecutive cycles.

## Test plan
- Single request: after reset, raise req=4'b0100 with byte 0xA5 → one cycle later send_data=1, ack=4'b0100, tx_data=0xA5, grant_id=2. Pulse tx_done 20 cycles later → busy falls the next cycle.
- Round-robin fairness: hold req=4'b1111 with distinct bytes and pulse tx_done 5 cycles after each send → grant order 0,1,2,3,0. Each ack is one-hot and coincides with send_data.
- Gap enforcement: GAP_CYCLES=3, continuous req on two requesters → each send_data occurs exactly 5 cycles after the prior tx_done. A spurious tx_done pulsed in GAP is ignored.
- Watchdog: TIMEOUT_CYCLES=10, never pulse tx_done → timeout_err=1 at the 10th WAIT cycle, then IDLE, and arbitration resumes. Also test tx_done on the expiry cycle → timeout_err stays 0.
- Request withdrawal: drop req in the cycle after arbitration → send_data and ack are still issued with the latched byte. A subsequent request from the same requester is served normally.
- Reset mid-WAIT: assert rst for 1 cycle → next cycle all outputs are at reset values. The first grant after reset goes to requester 0 when all requesters are requesting.
